// File: rtl/vrf_sram_arbiter.sv
// ============================================================================
// Module   : vrf_sram_arbiter
// Brief    : Round-robin two-requester front end for the single-port VRF SRAM,
//            with read-response routing and post-reset / on-demand zero-fill.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vrf_sram_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              clr_start,
  output logic              init_done,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_we,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam logic [0:0]        S_INIT    = 1'b0;
  localparam logic [0:0]        S_RUN     = 1'b1;
  localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(DEPTH - 1);

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_fill_cnt;
  logic              r_rr_ptr;
  logic [1:0]        r_rsp_valid;
  logic [ADDR_W-1:0] r_last_addr;
  logic [DATA_W-1:0] r_last_wdata;
  logic [1:0]        w_grant;

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:  if (r_fill_cnt == FILL_LAST) w_state_nxt = S_RUN;
      S_RUN:   if (clr_start)               w_state_nxt = S_INIT;
      default: w_state_nxt = S_INIT;
    endcase
  end

  // Outputs: readiness, grant and SRAM drive.  Idle RUN cycles replay the last
  // address/data as a harmless read so the SRAM pins do not toggle.
  always_comb begin
    init_done  = 1'b0;
    req_ready  = 2'b00;
    w_grant    = 2'b00;
    sram_we    = 1'b0;
    sram_addr  = r_last_addr;
    sram_wdata = r_last_wdata;
    case (r_state)
      S_INIT: begin
        sram_we    = 1'b1;
        sram_addr  = r_fill_cnt;
        sram_wdata = '0;
      end
      S_RUN: begin
        init_done = 1'b1;
        if (!clr_start) begin
          req_ready[0] = !req_valid[1] || (r_rr_ptr == 1'b0);
          req_ready[1] = !req_valid[0] || (r_rr_ptr == 1'b1);
        end
        w_grant = req_valid & req_ready;
        if (w_grant[0]) begin
          sram_we    = req_we[0];
          sram_addr  = req_addr0;
          sram_wdata = req_wdata0;
        end else if (w_grant[1]) begin
          sram_we    = req_we[1];
          sram_addr  = req_addr1;
          sram_wdata = req_wdata1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_fill_cnt <= '0;
    end else if (r_state == S_INIT) begin
      r_fill_cnt <= (r_fill_cnt == FILL_LAST) ? '0 : r_fill_cnt + ADDR_W'(1);
    end else begin
      r_fill_cnt <= '0;
    end
  end

  // Grant priority flips to the other requester after every transfer.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rr_ptr <= 1'b0;
    end else if (w_grant[0]) begin
      r_rr_ptr <= 1'b1;
    end else if (w_grant[1]) begin
      r_rr_ptr <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rsp_valid  <= 2'b00;
      r_last_addr  <= '0;
      r_last_wdata <= '0;
    end else begin
      r_rsp_valid  <= w_grant & ~req_we;
      r_last_addr  <= sram_addr;
      r_last_wdata <= sram_wdata;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = sram_rdata;

endmodule

`default_nettype wire

// File: tb/tb_vrf_sram_arbiter.sv
// ============================================================================
// Module   : tb_vrf_sram_arbiter
// Brief    : Directed + randomized bench for vrf_sram_arbiter with SRAM model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vrf_sram_arbiter;

  logic        clk;
  logic        nrst;
  logic        clr_start;
  logic        init_done;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [4:0]  req_addr0;
  logic [4:0]  req_addr1;
  logic [31:0] req_wdata0;
  logic [31:0] req_wdata1;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        sram_we;
  logic [4:0]  sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  int checks;
  int failures;

  vrf_sram_arbiter #(.ADDR_W(5), .DATA_W(32), .DEPTH(32)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .clr_start  (clr_start),
    .init_done  (init_done),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr0  (req_addr0),
    .req_addr1  (req_addr1),
    .req_wdata0 (req_wdata0),
    .req_wdata1 (req_wdata1),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM macro: array is not reset; while reset is held it is filled with garbage.
  logic [31:0] sram_mem [0:31];
  logic [4:0]  junk_idx = 5'd0;
  always @(posedge clk) begin
    if (!nrst) begin
      sram_mem[junk_idx] <= $urandom;
      junk_idx           <= junk_idx + 5'd1;
    end else if (sram_we) begin
      sram_mem[sram_addr] <= sram_wdata;
    end
  end
  always @(posedge clk or negedge nrst) begin
    if (!nrst)         sram_rdata <= 32'd0;
    else if (!sram_we) sram_rdata <= sram_mem[sram_addr];
  end

  // Reference model state
  bit          m_run;
  int          m_fill;
  bit          m_rr;
  logic [1:0]  m_pend;
  logic [31:0] m_pdata;
  logic [4:0]  m_laddr;
  logic [31:0] m_lwdata;
  logic [31:0] m_mem [0:31];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run    = 1'b0;
    m_fill   = 0;
    m_rr     = 1'b0;
    m_pend   = 2'b00;
    m_pdata  = 32'd0;
    m_laddr  = 5'd0;
    m_lwdata = 32'd0;
  endtask

  // One clock cycle: apply inputs, check outputs mid-cycle, advance the model.
  task automatic drive_cycle(input logic [1:0] v, input logic [1:0] we,
                             input logic [4:0] a0, input logic [4:0] a1,
                             input logic [31:0] d0, input logic [31:0] d1,
                             input logic clr);
    logic [1:0]  e_ready;
    logic [1:0]  g;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_wdata;
    req_valid  = v;
    req_we     = we;
    req_addr0  = a0;
    req_addr1  = a1;
    req_wdata0 = d0;
    req_wdata1 = d1;
    clr_start  = clr;
    @(negedge clk);
    e_ready = 2'b00;
    g       = 2'b00;
    e_we    = 1'b0;
    e_addr  = m_laddr;
    e_wdata = m_lwdata;
    if (!m_run) begin
      e_we    = 1'b1;
      e_addr  = 5'(m_fill);
      e_wdata = 32'd0;
    end else if (!clr) begin
      e_ready[0] = !v[1] || !m_rr;
      e_ready[1] = !v[0] || m_rr;
      if (v == 2'b11) g = m_rr ? 2'b10 : 2'b01;
      else            g = v;
      if (g[0])      begin e_we = we[0]; e_addr = a0; e_wdata = d0; end
      else if (g[1]) begin e_we = we[1]; e_addr = a1; e_wdata = d1; end
    end
    chk("init_done",  init_done,  m_run);
    chk("req_ready",  req_ready,  e_ready);
    chk("sram_we",    sram_we,    e_we);
    chk("sram_addr",  sram_addr,  e_addr);
    chk("sram_wdata", sram_wdata, e_wdata);
    chk("rsp_valid",  rsp_valid,  m_pend);
    if (m_pend != 2'b00) chk("rsp_rdata", rsp_rdata, m_pdata);
    m_pend = 2'b00;
    if (!m_run) begin
      m_mem[m_fill] = 32'd0;
      if (m_fill == 31) begin m_run = 1'b1; m_fill = 0; end
      else              m_fill = m_fill + 1;
    end else begin
      if (g != 2'b00) begin
        if (e_we) m_mem[e_addr] = e_wdata;
        else begin m_pend = g; m_pdata = m_mem[e_addr]; end
        m_rr = g[0];
      end
      if (clr) begin m_run = 1'b0; m_fill = 0; end
    end
    m_laddr  = e_addr;
    m_lwdata = e_wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive_cycle(2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic random_cycle(input bit allow_clr);
    logic clr;
    clr = allow_clr && ($urandom_range(0, 39) == 0);
    drive_cycle(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                $urandom, $urandom, clr);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    nrst       = 1'b0;
    clr_start  = 1'b0;
    req_valid  = 2'b00;
    req_we     = 2'b00;
    req_addr0  = 5'd0;
    req_addr1  = 5'd0;
    req_wdata0 = 32'd0;
    req_wdata1 = 32'd0;
    for (int i = 0; i < 32; i++) m_mem[i] = $urandom;
    model_reset();

    // Hold reset long enough for the SRAM array to be filled with garbage.
    repeat (34) @(posedge clk);
    @(negedge clk);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_sram_we",   sram_we,   1'b1);
    chk("rst_sram_addr", sram_addr, 5'd0);
    chk("rst_sram_wd",   sram_wdata, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    @(posedge clk);
    #1;
    nrst = 1'b1;

    // Zero-fill: 32 INIT cycles, then read addr 7 returns zero.
    repeat (32) idle();
    drive_cycle(2'b01, 2'b00, 5'd7, 5'd0, 32'd0, 32'd0, 1'b0);
    idle();

    // Write then read-after-write on requester 0.
    drive_cycle(2'b01, 2'b01, 5'd3, 5'd0, 32'hDEADBEEF, 32'd0, 1'b0);
    drive_cycle(2'b01, 2'b00, 5'd3, 5'd0, 32'd0, 32'd0, 1'b0);
    idle();

    // Distinct data at addr 1/2, then contending reads alternate grants.
    drive_cycle(2'b01, 2'b01, 5'd1, 5'd0, 32'hA5A5_0001, 32'd0, 1'b0);
    drive_cycle(2'b10, 2'b10, 5'd0, 5'd2, 32'd0, 32'h5A5A_0002, 1'b0);
    repeat (6) drive_cycle(2'b11, 2'b00, 5'd1, 5'd2, 32'd0, 32'd0, 1'b0);
    idle();

    // Lone requester 1 with priority at 0: back-to-back reads.
    for (int a = 0; a < 5; a++)
      drive_cycle(2'b10, 2'b00, 5'd0, 5'(a), 32'd0, 32'd0, 1'b0);
    idle();

    // clr_start with a read response in flight, then ready stays low while refilling.
    drive_cycle(2'b01, 2'b01, 5'd31, 5'd0, 32'h12345678, 32'd0, 1'b0);
    drive_cycle(2'b01, 2'b00, 5'd31, 5'd0, 32'd0, 32'd0, 1'b0);
    drive_cycle(2'b11, 2'b00, 5'd31, 5'd31, 32'd0, 32'd0, 1'b1);
    repeat (32) random_cycle(1'b0);
    drive_cycle(2'b01, 2'b00, 5'd31, 5'd0, 32'd0, 32'd0, 1'b0);
    idle();

    // Randomized traffic with occasional clear requests.
    repeat (400) random_cycle(1'b1);
    repeat (40) idle();

    // Reset asserted mid-read drops the pending response and restarts the fill.
    drive_cycle(2'b01, 2'b00, 5'd5, 5'd0, 32'd0, 32'd0, 1'b0);
    req_valid = 2'b00;
    nrst      = 1'b0;
    @(negedge clk);
    chk("midrst_rsp_valid", rsp_valid, 2'b00);
    chk("midrst_init_done", init_done, 1'b0);
    chk("midrst_sram_addr", sram_addr, 5'd0);
    chk("midrst_sram_we",   sram_we,   1'b1);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    model_reset();
    repeat (32) random_cycle(1'b0);
    repeat (60) random_cycle(1'b0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vrf_sram_arbiter.md
# vrf_sram_arbiter

Front-end controller for the single-port 32x32 vector-register SRAM: shares its one read/write port between two requesters with round-robin arbitration, and routes one-cycle-latency read data back to the requester that issued the read. After reset, and on request, it runs a zero-fill sequence over every word, because the SRAM array itself is not reset. It sits between the vector load/store unit (requester 0) and the vector execute unit (requester 1) on one side and the SRAM macro on the other.

## Interface
- ADDR_W, 5, SRAM address width
- DATA_W, 32, SRAM word width
- DEPTH, 32, number of words; must equal 2**ADDR_W
- clk  in  1  clock; all state changes on its rising edge
- nrst  in  1  reset, asynchronous, active-low
- clr_start  in  1  one-cycle pulse; restarts the zero-fill sequence (honoured only in RUN)
- init_done  out  1  high in RUN state
- req_valid[1:0]  in  2  per-requester request valid
- req_ready[1:0]  out  2  per-requester request accept
- req_we[1:0]  in  2  per-requester write enable; 0 = read
- req_addr0, req_addr1  in  ADDR_W  per-requester address
- req_wdata0, req_wdata1  in  DATA_W  per-requester write data
- rsp_valid[1:0]  out  2  per-requester read-response valid; exactly one cycle per accepted read
- rsp_rdata  out  DATA_W  read data shared by both requesters, qualified by rsp_valid
- sram_we  out  1  to SRAM write enable
- sram_addr  out  ADDR_W  to SRAM address
- sram_wdata  out  DATA_W  to SRAM write data
- sram_rdata  in  DATA_W  from SRAM; registered, valid the cycle after a we=0 cycle

## Operation
- States:
  - INIT: zero-fill. Drives sram_we=1, sram_addr=fill_cnt, sram_wdata=0; fill_cnt increments each cycle; req_ready=0.
  - RUN: arbitrated traffic.
- Transitions:
  - INIT -> RUN on the cycle fill_cnt==DEPTH-1, after that word is written; fill_cnt returns to 0.
  - RUN -> INIT when clr_start=1, with fill_cnt=0.
  - clr_start is ignored in INIT.
- Readiness in RUN, with clr_start=0 (combinational, independent of a requester's own valid):
  - req_ready[0] = !req_valid[1] || rr_ptr==0
  - req_ready[1] = !req_valid[0] || rr_ptr==1
- In the cycle clr_start=1, both req_ready are forced to 0.
- Transfer on requester i when req_valid[i] && req_ready[i]. At most one transfer per cycle.
- SRAM drive:
  - On a transfer, sram_we/addr/wdata come from the granted requester.
  - In RUN with no transfer: sram_we=0, and sram_addr/sram_wdata hold the last driven values. The idle read this causes is harmless and produces no response.
- Round-robin: on a transfer from i, rr_ptr <= 1-i. Otherwise rr_ptr holds. A lone valid requester is granted every cycle.
- Read response:
  - A read transfer from i at cycle t sets rsp_valid[i]=1 at cycle t+1.
  - rsp_rdata = sram_rdata (pass-through); rsp_valid is registered.
  - Responses have no backpressure; requesters must always sink them.
- Writes produce no response.
- Ordering:
  - Write addr A at t, read A at t+1: returns the new data at t+2.
  - Read A at t, write A at t+1: returns the old data.

## Timing
- Reset values:
  - state=INIT, fill_cnt=0, rr_ptr=0.
  - init_done=0, req_ready=2'b00, rsp_valid=2'b00.
  - sram_we=1, sram_addr=0, sram_wdata=0. Writes are harmless because the SRAM is held in the same reset.
  - rsp_rdata follows sram_rdata (0 under reset).
- After nrst deassertion: DEPTH INIT cycles (32 by default); init_done rises in cycle DEPTH; first request can be accepted in cycle DEPTH.
- Read latency: 1 cycle from accept to rsp_valid. Throughput: 1 access per cycle aggregate.
- clr_start while a read response is pending: the response is still delivered the next cycle (from the SRAM output register) before zero-fill writes affect anything.
- nrst asserted mid-operation: immediate return to reset values. A pending rsp_valid is dropped, and zero-fill restarts from address 0.

## Test plan
- Reset release, no requests -> init_done=0 for 32 cycles with sram_addr 0..31, sram_we=1, sram_wdata=0; init_done=1 in cycle 32; then read addr 7 -> rsp_valid[0] one cycle later with rsp_rdata=0.
- Requester 0 writes 0xDEADBEEF to addr 3, then reads addr 3 in the next cycle -> rsp_valid[0] with 0xDEADBEEF two cycles after the write; rsp_valid[1] stays 0.
- Both requesters hold valid reads (addr 1, addr 2) for 6 cycles -> grants alternate 0,1,0,1,0,1; each rsp_valid pulses every other cycle with the correct data.
- Only requester 1 valid, with rr_ptr=0 -> req_ready[1]=1 every cycle, back-to-back reads of addrs 0..4 return data in consecutive cycles.
- Write 0x12345678 to addr 31, pulse clr_start in the same cycle as a read accept on addr 31 from the prior cycle -> that response is delivered, ready=0 for 33 cycles, then a read of addr 31 returns 0.
- Assert nrst for 1 cycle mid-read -> rsp_valid=0 the next cycle, fill restarts at addr 0, init_done low for 32 cycles.
